multicycle_maindec: RTL and testbench
=====================================

# multicycle_maindec

Main control FSM for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives every datapath enable and mux select, and produces the 2-bit `aluop` consumed by the ALU decoder: 00 = add, 01 = subtract, 10 = decode by funct. It also forms the PC enable from `pcwrite`, `branch` and the ALU zero flag.

## Interface
Parameters:
- none.

Ports:
- `clk`  in  1  — system clock; all state changes on the rising edge.
- `rst_n`  in  1  — reset; **one clock; reset is synchronous and active-low**.
- `op`  in  6  — opcode field from the instruction register; stable from DECODE to the end of the instruction.
- `zero`  in  1  — ALU zero flag, combinational from the datapath.
- `pcen`  out  1  — PC register enable.
- `pcwrite`  out  1  — unconditional PC write request.
- `branch`  out  1  — conditional PC write request.
- `irwrite`  out  1  — instruction register load.
- `memwrite`  out  1  — data memory write.
- `regwrite`  out  1  — register file write.
- `iord`  out  1  — memory address select: 0 = PC, 1 = ALUOut.
- `alusrca`  out  1  — ALU A select: 0 = PC, 1 = register A.
- `alusrcb`  out  2  — ALU B select: 00 = B, 01 = 4, 10 = signext, 11 = signext<<2.
- `regdst`  out  1  — write-register select: 0 = rt, 1 = rd.
- `memtoreg`  out  1  — writeback data select: 0 = ALUOut, 1 = MDR.
- `pcsrc`  out  2  — next-PC select: 00 = ALU, 01 = ALUOut, 10 = jump target.
- `aluop`  out  2  — ALU operation class sent to the ALU decoder.
- `state`  out  4  — current state, for debug and verification.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- State encoding (4-bit): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11.
- Transitions:
  - FETCH→DECODE.
  - DECODE: lw/sw→MEMADR; R→EXECUTE; beq→BRANCH; addi→ADDIEXEC; j→JUMP; any other op→FETCH.
  - MEMADR: lw→MEMRD, otherwise→MEMWR.
  - MEMRD→MEMWB.
  - EXECUTE→ALUWB.
  - ADDIEXEC→ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP→FETCH.
- Codes 12–15 are illegal: next state is FETCH and all outputs are 0.
- Moore outputs decoded from `state`. Any output not listed for a state is 0.
  - FETCH: `irwrite`=1, `pcwrite`=1, `alusrcb`=01, `aluop`=00, `pcsrc`=00, `iord`=0, `alusrca`=0.
  - DECODE: `alusrcb`=11, `aluop`=00.
  - MEMADR, ADDIEXEC: `alusrca`=1, `alusrcb`=10, `aluop`=00.
  - MEMRD: `iord`=1.
  - MEMWB: `memtoreg`=1, `regwrite`=1.
  - MEMWR: `iord`=1, `memwrite`=1.
  - EXECUTE: `alusrca`=1, `alusrcb`=00, `aluop`=10.
  - ALUWB: `regdst`=1, `regwrite`=1.
  - ADDIWB: `regwrite`=1.
  - BRANCH: `alusrca`=1, `aluop`=01, `pcsrc`=01, `branch`=1.
  - JUMP: `pcsrc`=10, `pcwrite`=1.
- `pcen = pcwrite | (branch & zero)`, combinational.

## Timing
- Reset: while `rst_n`=0 at a rising edge, `state`←FETCH.
- While `rst_n`=0, these outputs are forced to 0 regardless of state: `pcen`, `pcwrite`, `branch`, `irwrite`, `memwrite`, `regwrite`.
- During reset, mux selects show FETCH values: `alusrcb`=01, all others 0.
- The first fetch occurs in the first cycle with `rst_n`=1.
- Reset asserted mid-instruction aborts it at the next edge. No write enable is asserted in any cycle where `rst_n`=0.
- Cycles per instruction, FETCH through the last state: lw 5, sw 4, R 4, addi 4, beq 3, j 3, unknown op 2.
- `op` is sampled only in DECODE and MEMADR.
- `zero` affects only `pcen`, and only in BRANCH. There is no added latency.

## Structure
- Shared package `mips_pkg`:
  - state enum/localparams;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - aluop constants (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10);
  - `alusrcb` and `pcsrc` select constants.
- Sub-module `mc_outdec`: purely combinational state→control-word decoder, with the reset gating applied at top level. The state register and next-state logic stay in `multicycle_maindec`.

## Test plan
- Reset then R-type: hold `rst_n`=0 for 3 cycles → all write enables 0 and `state`=0. Release with `op`=000000 → states 0,1,6,7,0. `aluop`=10 in EXECUTE, `regwrite`=`regdst`=1 in ALUWB.
- lw then sw: `op`=100011 → states 0,1,2,3,4,0, with `memtoreg`=1 and `regwrite`=1 in MEMWB. `op`=101011 → states 0,1,2,5,0, with `memwrite`=`iord`=1 in MEMWR.
- beq both ways: `op`=000100 with `zero`=1 in BRANCH → `pcen`=1, `pcsrc`=01, `aluop`=01. With `zero`=0 → `pcen`=0. Both end back in FETCH after 3 cycles.
- addi and j: `op`=001000 → states 0,1,9,10,0, with `alusrcb`=10 in ADDIEXEC. `op`=000010 → states 0,1,11,0, with `pcwrite`=`pcen`=1 and `pcsrc`=10 in JUMP.
- Illegal op: `op`=111111 → DECODE→FETCH, with no write enable asserted in DECODE.
- Mid-instruction reset: assert `rst_n`=0 during MEMWR → `memwrite`=0 in that same cycle and `state`=0 next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: state encoding,
// opcodes, datapath select codes and the packed control word.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } statetype;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       regdst;
    logic       memtoreg;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/multicycle_maindec_if.sv
// Control bus between the main decoder (master) and the multicycle datapath.
interface multicycle_maindec_if;
  logic [5:0] op;
  logic       zero;
  logic       pcen;
  logic       pcwrite;
  logic       branch;
  logic       irwrite;
  logic       memwrite;
  logic       regwrite;
  logic       iord;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       regdst;
  logic       memtoreg;
  logic [1:0] pcsrc;
  logic [1:0] aluop;
  logic [3:0] state;

  modport master (
    input  op, zero,
    output pcen, pcwrite, branch, irwrite, memwrite, regwrite, iord,
           alusrca, alusrcb, regdst, memtoreg, pcsrc, aluop, state
  );

  modport slave (
    output op, zero,
    input  pcen, pcwrite, branch, irwrite, memwrite, regwrite, iord,
           alusrca, alusrcb, regdst, memtoreg, pcsrc, aluop, state
  );
endinterface

// File: rtl/mc_outdec.sv
// Combinational state -> control word decoder (Moore outputs, no reset gating).
module mc_outdec
  import mips_pkg::*;
(
  input  statetype state,
  output ctrl_t    cw
);

  always_comb begin
    cw = '0;
    case (state)
      FETCH: begin
        cw.irwrite = 1'b1;
        cw.pcwrite = 1'b1;
        cw.alusrcb = SRCB_FOUR;
        cw.aluop   = ALUOP_ADD;
        cw.pcsrc   = PCSRC_ALU;
      end
      DECODE: begin
        cw.alusrcb = SRCB_IMMSH;
        cw.aluop   = ALUOP_ADD;
      end
      MEMADR, ADDIEXEC: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_IMM;
        cw.aluop   = ALUOP_ADD;
      end
      MEMRD: cw.iord = 1'b1;
      MEMWB: begin
        cw.memtoreg = 1'b1;
        cw.regwrite = 1'b1;
      end
      MEMWR: begin
        cw.iord     = 1'b1;
        cw.memwrite = 1'b1;
      end
      EXECUTE: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_REG;
        cw.aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        cw.regdst   = 1'b1;
        cw.regwrite = 1'b1;
      end
      ADDIWB: cw.regwrite = 1'b1;
      BRANCH: begin
        cw.alusrca = 1'b1;
        cw.aluop   = ALUOP_SUB;
        cw.pcsrc   = PCSRC_ALUOUT;
        cw.branch  = 1'b1;
      end
      JUMP: begin
        cw.pcsrc   = PCSRC_JUMP;
        cw.pcwrite = 1'b1;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_maindec.sv
// Main control FSM for the multicycle MIPS datapath: state register, next-state
// logic, reset gating of the decoded control word and PC enable.
module multicycle_maindec
  import mips_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  multicycle_maindec_if.master        bus
);

  statetype state_q;
  statetype state_nx;
  ctrl_t    cw_dec;
  ctrl_t    cw;

  always_comb begin
    state_nx = FETCH;
    case (state_q)
      FETCH: state_nx = DECODE;
      DECODE: begin
        if (is_mem_op(bus.op))        state_nx = MEMADR;
        else if (bus.op == OP_RTYPE)  state_nx = EXECUTE;
        else if (bus.op == OP_BEQ)    state_nx = BRANCH;
        else if (bus.op == OP_ADDI)   state_nx = ADDIEXEC;
        else if (bus.op == OP_J)      state_nx = JUMP;
        else                          state_nx = FETCH;
      end
      MEMADR:   state_nx = (bus.op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:    state_nx = MEMWB;
      EXECUTE:  state_nx = ALUWB;
      ADDIEXEC: state_nx = ADDIWB;
      default:  state_nx = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_nx;
  end

  mc_outdec u_outdec (
    .state (state_q),
    .cw    (cw_dec)
  );

  // In reset, present the FETCH mux selects with every write enable dropped,
  // even if the state register still holds an aborted instruction's state.
  always_comb begin
    cw = cw_dec;
    if (!rst_n) begin
      cw         = '0;
      cw.alusrcb = SRCB_FOUR;
    end
  end

  assign bus.pcen     = cw.pcwrite | (cw.branch & bus.zero);
  assign bus.pcwrite  = cw.pcwrite;
  assign bus.branch   = cw.branch;
  assign bus.irwrite  = cw.irwrite;
  assign bus.memwrite = cw.memwrite;
  assign bus.regwrite = cw.regwrite;
  assign bus.iord     = cw.iord;
  assign bus.alusrca  = cw.alusrca;
  assign bus.alusrcb  = cw.alusrcb;
  assign bus.regdst   = cw.regdst;
  assign bus.memtoreg = cw.memtoreg;
  assign bus.pcsrc    = cw.pcsrc;
  assign bus.aluop    = cw.aluop;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_multicycle_maindec.sv
// Scoreboard bench for multicycle_maindec: directed instruction sequences push
// hand-written expected state/control words; a negedge monitor checks them.
module tb_multicycle_maindec;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  multicycle_maindec_if bus ();

  multicycle_maindec dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [3:0] st;
    logic [14:0] cw;
    logic       pcen;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int vec = 0;

  // Order: pcwrite,branch,irwrite,memwrite,regwrite,iord,alusrca,
  //        alusrcb[2],regdst,memtoreg,pcsrc[2],aluop[2]
  localparam logic [14:0] CW_RST = 15'b0_0_0_0_0_0_0_01_0_0_00_00;

  function automatic logic [14:0] exp_cw(input logic [3:0] st);
    case (st)
      4'd0:  return 15'b1_0_1_0_0_0_0_01_0_0_00_00;
      4'd1:  return 15'b0_0_0_0_0_0_0_11_0_0_00_00;
      4'd2:  return 15'b0_0_0_0_0_0_1_10_0_0_00_00;
      4'd3:  return 15'b0_0_0_0_0_1_0_00_0_0_00_00;
      4'd4:  return 15'b0_0_0_0_1_0_0_00_0_1_00_00;
      4'd5:  return 15'b0_0_0_1_0_1_0_00_0_0_00_00;
      4'd6:  return 15'b0_0_0_0_0_0_1_00_0_0_00_10;
      4'd7:  return 15'b0_0_0_0_1_0_0_00_1_0_00_00;
      4'd8:  return 15'b0_1_0_0_0_0_1_00_0_0_01_01;
      4'd9:  return 15'b0_0_0_0_0_0_1_10_0_0_00_00;
      4'd10: return 15'b0_0_0_0_1_0_0_00_0_0_00_00;
      4'd11: return 15'b1_0_0_0_0_0_0_00_0_0_10_00;
      default: return 15'b0;
    endcase
  endfunction

  task automatic step(input logic r, input logic [5:0] o, input logic z,
                      input logic [3:0] st, input logic pc);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n   = r;
    bus.op  = o;
    bus.zero = z;
    e.idx  = vec;
    e.st   = st;
    e.cw   = r ? exp_cw(st) : CW_RST;
    e.pcen = pc;
    sb.push_back(e);
    vec++;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      logic [14:0] got;
      e = sb.pop_front();
      got = {bus.pcwrite, bus.branch, bus.irwrite, bus.memwrite, bus.regwrite,
             bus.iord, bus.alusrca, bus.alusrcb, bus.regdst, bus.memtoreg,
             bus.pcsrc, bus.aluop};
      checks++;
      if (bus.state !== e.st) begin
        failures++;
        $display("FAIL state v%0d: got %0d want %0d", e.idx, bus.state, e.st);
      end
      checks++;
      if (got !== e.cw) begin
        failures++;
        $display("FAIL ctrl v%0d (state %0d): got %b want %b", e.idx, e.st, got, e.cw);
      end
      checks++;
      if (bus.pcen !== e.pcen) begin
        failures++;
        $display("FAIL pcen v%0d (state %0d): got %b want %b", e.idx, e.st, bus.pcen, e.pcen);
      end
    end
  end

  initial begin
    bus.op   = 6'b000000;
    bus.zero = 1'b0;

    // reset held for 3 cycles
    repeat (3) step(1'b0, 6'b000000, 1'b0, 4'd0, 1'b0);

    // R-type: 0,1,6,7
    step(1'b1, 6'b000000, 1'b0, 4'd0, 1'b1);
    step(1'b1, 6'b000000, 1'b0, 4'd1, 1'b0);
    step(1'b1, 6'b000000, 1'b0, 4'd6, 1'b0);
    step(1'b1, 6'b000000, 1'b0, 4'd7, 1'b0);

    // lw: 0,1,2,3,4
    step(1'b1, 6'b100011, 1'b0, 4'd0, 1'b1);
    step(1'b1, 6'b100011, 1'b0, 4'd1, 1'b0);
    step(1'b1, 6'b100011, 1'b0, 4'd2, 1'b0);
    step(1'b1, 6'b100011, 1'b0, 4'd3, 1'b0);
    step(1'b1, 6'b100011, 1'b0, 4'd4, 1'b0);

    // sw: 0,1,2,5
    step(1'b1, 6'b101011, 1'b0, 4'd0, 1'b1);
    step(1'b1, 6'b101011, 1'b0, 4'd1, 1'b0);
    step(1'b1, 6'b101011, 1'b0, 4'd2, 1'b0);
    step(1'b1, 6'b101011, 1'b0, 4'd5, 1'b0);

    // beq taken: zero high throughout, only BRANCH's pcen depends on it
    step(1'b1, 6'b000100, 1'b1, 4'd0, 1'b1);
    step(1'b1, 6'b000100, 1'b1, 4'd1, 1'b0);
    step(1'b1, 6'b000100, 1'b1, 4'd8, 1'b1);

    // beq not taken
    step(1'b1, 6'b000100, 1'b0, 4'd0, 1'b1);
    step(1'b1, 6'b000100, 1'b0, 4'd1, 1'b0);
    step(1'b1, 6'b000100, 1'b0, 4'd8, 1'b0);

    // addi: 0,1,9,10
    step(1'b1, 6'b001000, 1'b0, 4'd0, 1'b1);
    step(1'b1, 6'b001000, 1'b0, 4'd1, 1'b0);
    step(1'b1, 6'b001000, 1'b0, 4'd9, 1'b0);
    step(1'b1, 6'b001000, 1'b0, 4'd10, 1'b0);

    // j: 0,1,11
    step(1'b1, 6'b000010, 1'b0, 4'd0, 1'b1);
    step(1'b1, 6'b000010, 1'b0, 4'd1, 1'b0);
    step(1'b1, 6'b000010, 1'b0, 4'd11, 1'b1);

    // illegal op: 0,1 then back to 0
    step(1'b1, 6'b111111, 1'b0, 4'd0, 1'b1);
    step(1'b1, 6'b111111, 1'b0, 4'd1, 1'b0);

    // sw aborted by reset while in MEMWR
    step(1'b1, 6'b101011, 1'b0, 4'd0, 1'b1);
    step(1'b1, 6'b101011, 1'b0, 4'd1, 1'b0);
    step(1'b1, 6'b101011, 1'b0, 4'd2, 1'b0);
    step(1'b0, 6'b101011, 1'b0, 4'd5, 1'b0);
    step(1'b1, 6'b000010, 1'b0, 4'd0, 1'b1);
    step(1'b1, 6'b000010, 1'b0, 4'd1, 1'b0);
    step(1'b1, 6'b000010, 1'b0, 4'd11, 1'b1);
    step(1'b1, 6'b000010, 1'b0, 4'd0, 1'b1);

    begin
      int waited = 0;
      while (sb.size() != 0 && waited < 20) begin
        @(posedge clk);
        waited++;
      end
      checks++;
      if (sb.size() != 0) begin
        failures++;
        $display("FAIL drain: %0d entries left, want 0", sb.size());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
